// File: rtl/aes_stream_frontend.sv
// AXI-Stream front end for aes_controller: gathers a command + payload packet into
// the controller's flat input FIFO, starts it, and streams the flat output FIFO back.
module aes_stream_frontend #(
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [31:0]              aes_cmd,
  output logic [FIFO_DEPTH*32-1:0] in_fifo,
  output logic [31:0]              in_fifo_last,
  output logic                     ctrl_en,
  input  logic [FIFO_DEPTH*32-1:0] out_fifo,
  input  logic                     ctrl_done,
  output logic                     busy,
  output logic                     err_o
);

  localparam logic [31:0] CMD_ENCRYPT = 32'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_START,
    ST_WAIT,
    ST_TX
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_cnt;
  logic [PTR_W-2:0] wr_idx;
  logic [PTR_W-2:0] rd_idx;
  logic             overflow;
  logic             rx_open;
  logic             s_hs;
  logic             m_hs;
  logic             wr_en;
  logic             wr_full;
  logic             rx_len_ok;
  logic             rd_is_last;

  // Ready is gated by reset so it reads 0 while reset is held, not just after.
  assign s_axis_tready = rx_open & reset;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = m_axis_tvalid & m_axis_tready;

  assign wr_cnt     = wr_ptr + PTR_W'(1);
  assign wr_full    = (wr_ptr == PTR_W'(FIFO_DEPTH));
  assign wr_idx     = wr_ptr[PTR_W-2:0];
  assign rd_idx     = rd_ptr[PTR_W-2:0];
  assign wr_en      = (state == ST_RX) & s_hs & ~wr_full;
  assign rx_len_ok  = ~overflow & ~wr_full & (wr_cnt[1:0] == 2'b00);
  assign rd_is_last = (32'(rd_ptr) == in_fifo_last - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (s_hs && !s_axis_tlast) state_nxt = ST_RX;
      ST_RX:    if (s_hs && s_axis_tlast) state_nxt = rx_len_ok ? ST_START : ST_IDLE;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (ctrl_done) state_nxt = (aes_cmd == CMD_ENCRYPT) ? ST_TX : ST_IDLE;
      ST_TX:    if (m_hs && rd_is_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_open       = 1'b0;
    ctrl_en       = 1'b0;
    busy          = 1'b1;
    m_axis_tvalid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        rx_open = 1'b1;
        busy    = 1'b0;
      end
      ST_RX:    rx_open       = 1'b1;
      ST_START: ctrl_en       = 1'b1;
      ST_TX:    m_axis_tvalid = 1'b1;
      default: ;
    endcase
  end

  // rd_ptr only moves on a handshake, so data and last hold steady under backpressure.
  assign m_axis_tdata = m_axis_tvalid ? out_fifo[{rd_idx, 5'b00000} +: 32] : '0;
  assign m_axis_tlast = m_axis_tvalid & rd_is_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aes_cmd      <= '0;
      in_fifo_last <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (s_hs) begin
            aes_cmd  <= s_axis_tdata;
            wr_ptr   <= '0;
            overflow <= 1'b0;
            if (s_axis_tlast) err_o <= 1'b1;
          end
        end
        ST_RX: begin
          if (s_hs) begin
            if (wr_full) overflow <= 1'b1;
            else         wr_ptr   <= wr_cnt;
            if (s_axis_tlast) begin
              if (rx_len_ok) in_fifo_last <= 32'(wr_cnt);
              else           err_o        <= 1'b1;
            end
          end
        end
        ST_WAIT: if (ctrl_done && aes_cmd == CMD_ENCRYPT) rd_ptr <= '0;
        ST_TX:   if (m_hs) rd_ptr <= rd_ptr + PTR_W'(1);
        default: ;
      endcase
    end
  end

  // Words past the current count are left untouched between packets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_fifo <= '0;
    end else if (wr_en) begin
      in_fifo[{wr_idx, 5'b00000} +: 32] <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_aes_stream_frontend.sv
// Scoreboard bench for aes_stream_frontend with a shallow FIFO: random packets are
// judged by a packet-level model; a monitor pops expectations as the DUT responds.
module tb_aes_stream_frontend;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;
  localparam int unsigned FW    = DEPTH * 32;

  logic          clk;
  logic          reset;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [31:0]   aes_cmd;
  logic [FW-1:0] in_fifo;
  logic [31:0]   in_fifo_last;
  logic          ctrl_en;
  logic [FW-1:0] out_fifo;
  logic          ctrl_done;
  logic          busy;
  logic          err_o;

  aes_stream_frontend #(.FIFO_DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .aes_cmd      (aes_cmd),
    .in_fifo      (in_fifo),
    .in_fifo_last (in_fifo_last),
    .ctrl_en      (ctrl_en),
    .out_fifo     (out_fifo),
    .ctrl_done    (ctrl_done),
    .busy         (busy),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [31:0]   cmd;
    logic [31:0]   last;
    logic [FW-1:0] fifo;
  } ev_t;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } beat_t;

  ev_t         exp_ev[$];
  beat_t       exp_out[$];
  int          checks   = 0;
  int          failures = 0;
  int          out_hs   = 0;
  int          tready_mode = 0;
  logic [31:0] mdl_fifo[DEPTH];
  logic [31:0] mdl_last;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Monitor: everything the DUT presents is checked against the queues.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    bit          prev_last;
    beat_t       b;
    ev_t         e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", FW'(m_axis_tvalid), FW'(1));
          check("stall_data", FW'(m_axis_tdata), FW'(prev_data));
          check("stall_last", FW'(m_axis_tlast), FW'(prev_last));
        end
        if (m_axis_tvalid || ctrl_en) check("s_ready_low", FW'(s_axis_tready), FW'(0));
        if (m_axis_tvalid && exp_out.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_tvalid actual=1 expected=0");
        end
        if (m_axis_tvalid && m_axis_tready && exp_out.size() > 0) begin
          b = exp_out.pop_front();
          check("out_data", FW'(m_axis_tdata), FW'(b.data));
          check("out_last", FW'(m_axis_tlast), FW'(b.last));
          out_hs++;
        end
        if (ctrl_en || err_o) begin
          if (exp_ev.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=en%0d_err%0d expected=none", ctrl_en, err_o);
          end else begin
            e = exp_ev.pop_front();
            check("ev_err", FW'(err_o), FW'(e.is_err));
            check("ev_start", FW'(ctrl_en), FW'(!e.is_err));
            check("ev_cmd", FW'(aes_cmd), FW'(e.cmd));
            check("ev_last", FW'(in_fifo_last), FW'(e.last));
            check("ev_fifo", in_fifo, e.fifo);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  initial begin
    bit [3:0] pat;
    int       k;
    pat = 4'b1001;
    k = 0;
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = pat[k % 4];
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  task automatic xfer(input logic [31:0] d, input bit last, input bit no_gap, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    if (!no_gap) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) done = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
      if (!done && waits > 400) begin
        fail_now("s_handshake");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'($urandom_range(0, 1));
    s_axis_tdata  = $urandom;
  endtask

  // Packet-level model: store what fits, accept only non-empty multiples of 4 that fit.
  task automatic send_pkt(input logic [31:0] cmd, input int n, input bit no_gap, output bit ok);
    logic [31:0] w[$];
    ev_t         e;
    int          wt;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    for (int i = 0; i < n && i < int'(DEPTH); i++) mdl_fifo[i] = w[i];
    ok = (n > 0) && (n <= int'(DEPTH)) && (n % 4 == 0);
    if (ok) mdl_last = 32'(n);
    e.is_err = !ok;
    e.cmd    = cmd;
    e.last   = mdl_last;
    for (int i = 0; i < int'(DEPTH); i++) e.fifo[i*32 +: 32] = mdl_fifo[i];
    exp_ev.push_back(e);
    xfer(cmd, n == 0, no_gap, wt);
    if (no_gap) check("cmd_no_stall", FW'(wt), FW'(0));
    for (int i = 0; i < n; i++) begin
      xfer(w[i], i == n - 1, no_gap, wt);
      if (no_gap) check("word_no_stall", FW'(wt), FW'(0));
    end
  endtask

  task automatic respond(input logic [31:0] cmd, input int n);
    int cyc;
    int d;
    cyc = 0;
    while (!ctrl_en && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!ctrl_en) begin
      fail_now("ctrl_en_wait");
      return;
    end
    @(posedge clk);
    #1;
    d = $urandom_range(0, 3);
    repeat (d) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < int'(DEPTH); i++) out_fifo[i*32 +: 32] = $urandom;
    if (cmd == 32'h20)
      for (int i = 0; i < n; i++) exp_out.push_back('{data: out_fifo[i*32 +: 32], last: (i == n - 1)});
    ctrl_done = 1'b1;
    @(posedge clk);
    #1;
    ctrl_done = 1'b0;
    check("done_to_tvalid", FW'(m_axis_tvalid), FW'(cmd == 32'h20));
    check("busy_after_done", FW'(busy), FW'(cmd == 32'h20));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_out.size() != 0 || exp_ev.size() != 0 || busy) && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (exp_out.size() != 0 || exp_ev.size() != 0 || busy) fail_now("drain");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_tvalid"}, FW'(m_axis_tvalid), FW'(0));
    check({tag, "_m_tdata"}, FW'(m_axis_tdata), FW'(0));
    check({tag, "_m_tlast"}, FW'(m_axis_tlast), FW'(0));
    check({tag, "_s_tready"}, FW'(s_axis_tready), FW'(0));
    check({tag, "_ctrl_en"}, FW'(ctrl_en), FW'(0));
    check({tag, "_err"}, FW'(err_o), FW'(0));
    check({tag, "_busy"}, FW'(busy), FW'(0));
    check({tag, "_aes_cmd"}, FW'(aes_cmd), FW'(0));
    check({tag, "_in_last"}, FW'(in_fifo_last), FW'(0));
    check({tag, "_in_fifo"}, in_fifo, FW'(0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mdl_fifo[i] = '0;
    mdl_last = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          n;
    int          base;
    int          cyc;
    logic [31:0] cmd;
    reset         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    out_fifo      = '0;
    ctrl_done     = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    #1;
    check("ready_after_release", FW'(s_axis_tready), FW'(1));
    @(posedge clk);
    #1;

    // Key load, then a stray done while idle.
    send_pkt(32'h10, 8, 1'b0, ok);
    respond(32'h10, 8);
    drain();
    ctrl_done = 1'b1;
    @(posedge clk);
    #1;
    ctrl_done = 1'b0;
    check("stray_done_busy", FW'(busy), FW'(0));
    check("stray_done_tvalid", FW'(m_axis_tvalid), FW'(0));

    tready_mode = 1;
    send_pkt(32'h20, 8, 1'b0, ok);
    respond(32'h20, 8);
    drain();

    send_pkt(32'h20, 0, 1'b0, ok);
    drain();
    send_pkt(32'h20, 5, 1'b0, ok);
    drain();
    send_pkt(32'h20, 12, 1'b1, ok);
    drain();

    for (int it = 0; it < 10; it++) begin
      tready_mode = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       cmd = 32'h10;
        1:       cmd = 32'h20;
        default: cmd = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) n = 4 * $urandom_range(1, 2);
      else n = $urandom_range(0, 10);
      send_pkt(cmd, n, 1'b0, ok);
      if (ok) respond(cmd, n);
      drain();
    end

    // Back-to-back: second command waits while the first packet streams out.
    tready_mode = 1;
    send_pkt(32'h20, 8, 1'b0, ok);
    respond(32'h20, 8);
    send_pkt(32'h20, 4, 1'b0, ok);
    respond(32'h20, 4);
    drain();

    // Reset after three of eight output words.
    tready_mode = 2;
    base = out_hs;
    send_pkt(32'h20, 8, 1'b0, ok);
    respond(32'h20, 8);
    cyc = 0;
    while (out_hs < base + 3 && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (out_hs < base + 3) fail_now("three_words");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("mid_tx_reset");
    exp_out.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_after_rerelease", FW'(s_axis_tready), FW'(1));
    @(posedge clk);
    #1;
    send_pkt(32'h20, 8, 1'b0, ok);
    respond(32'h20, 8);
    drain();

    check("ev_queue_empty", FW'(exp_ev.size()), FW'(0));
    check("out_queue_empty", FW'(exp_out.size()), FW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
